// File: rtl/t1_pack_encoder.sv
// Packs 10-bit t1 coefficients LSB-first into a byte stream (4 coeffs -> 5 bytes).
// Show-ahead input FIFO absorbs upstream bursts; output uses registered valid/ready.
module t1_pack_encoder #(
   parameter int WIDTH      = 24,
   parameter int FIFO_DEPTH = 16,
   parameter int N_COEFF    = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [7:0]       o_data,
   output logic             o_last,
   output logic             o_busy,
   output logic             o_err_ovf,
   output logic             o_err_range
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int NBYTES = N_COEFF * 10 / 8;
   localparam int BW     = $clog2(NBYTES);
   localparam int CW     = $clog2(N_COEFF);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
   localparam logic [CW-1:0] LAST_COEF = CW'(N_COEFF - 1);

   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, full_d;
   logic [23:0]   acc_q, acc_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0] coef_cnt_q, coef_cnt_d;
   logic [BW-1:0] byte_cnt_q, byte_cnt_d;
   logic          o_valid_q, o_valid_d;
   logic [7:0]    o_data_q, o_data_d;
   logic          o_last_q, o_last_d;
   logic          ovf_q, ovf_d;
   logic          range_q, range_d;
   logic          wr_en, fetch, emit;

   always_comb begin
      wr_en = i_valid && !full_q;
      fetch = (bit_cnt_q < 5'd8) && (cnt_q != '0);
      emit  = (bit_cnt_q >= 5'd8) && (!o_valid_q || o_ready);

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      bit_cnt_d  = bit_cnt_q;
      coef_cnt_d = coef_cnt_q;
      byte_cnt_d = byte_cnt_q;
      o_valid_d  = o_valid_q;
      o_data_d   = o_data_q;
      o_last_d   = o_last_q;
      ovf_d      = ovf_q | (i_valid && full_q);
      range_d    = range_q | (wr_en && ((i_data >> 10) != '0));

      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_en && !fetch) cnt_d = cnt_q + 1'b1;
      else if (!wr_en && fetch) cnt_d = cnt_q - 1'b1;
      full_d = (cnt_d == FULL_CNT);

      // fetch needs bit_cnt < 8 and emit needs >= 8, so at most one touches acc
      if (fetch) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         acc_d      = acc_q | ({14'd0, mem_q[rd_ptr_q]} << bit_cnt_q);
         bit_cnt_d  = bit_cnt_q + 5'd10;
         coef_cnt_d = (coef_cnt_q == LAST_COEF) ? '0 : coef_cnt_q + 1'b1;
      end

      if (emit) begin
         o_data_d   = acc_q[7:0];
         acc_d      = acc_q >> 8;
         bit_cnt_d  = bit_cnt_q - 5'd8;
         o_valid_d  = 1'b1;
         o_last_d   = (byte_cnt_q == LAST_BYTE);
         byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
      end else if (o_valid_q && o_ready) begin
         o_valid_d = 1'b0;
         o_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= i_data[9:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         acc_q      <= '0;
         bit_cnt_q  <= '0;
         coef_cnt_q <= '0;
         byte_cnt_q <= '0;
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
         o_last_q   <= 1'b0;
         ovf_q      <= 1'b0;
         range_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         acc_q      <= acc_d;
         bit_cnt_q  <= bit_cnt_d;
         coef_cnt_q <= coef_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         o_valid_q  <= o_valid_d;
         o_data_q   <= o_data_d;
         o_last_q   <= o_last_d;
         ovf_q      <= ovf_d;
         range_q    <= range_d;
      end
   end

   assign i_ready     = !full_q;
   assign o_valid     = o_valid_q;
   assign o_data      = o_data_q;
   assign o_last      = o_last_q;
   assign o_busy      = (cnt_q != '0) || (bit_cnt_q != '0) || o_valid_q;
   assign o_err_ovf   = ovf_q;
   assign o_err_range = range_q;
endmodule

// File: tb/tb_t1_pack_encoder.sv
// Bench for t1_pack_encoder: table vectors plus streamed polynomials checked
// against a bit-serial packing model through an expected-byte queue.
module tb_t1_pack_encoder;
   localparam int WIDTH = 24;
   localparam int DEPTH = 16;
   localparam int NC    = 256;
   localparam int NB    = 320;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_valid = 1'b0;
   logic             i_ready;
   logic [WIDTH-1:0] i_data = '0;
   logic             o_valid;
   logic             o_ready = 1'b1;
   logic [7:0]       o_data;
   logic             o_last;
   logic             o_busy;
   logic             o_err_ovf;
   logic             o_err_range;

   t1_pack_encoder #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .N_COEFF(NC)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
      .o_busy(o_busy), .o_err_ovf(o_err_ovf), .o_err_range(o_err_range)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] coef [4];
      logic [7:0]  exp_b [5];
      logic        exp_rng;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q [$];
   logic       bits_q [$];
   int         exp_idx = 0;
   int         got_bytes = 0;
   int         got_last = 0;
   logic       stall_prev = 1'b0;
   logic [8:0] stall_val = '0;
   logic [8:0] mon_e;
   bit         tog_stop;
   vec_t       vecs [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [7:0] b);
      exp_q.push_back({(exp_idx == NB-1), b});
      exp_idx = (exp_idx == NB-1) ? 0 : exp_idx + 1;
   endtask

   // Serial model: append the 10 low bits, peel off whole bytes LSB-first.
   task automatic model_coef(input logic [23:0] c);
      logic [7:0] b;
      for (int i = 0; i < 10; i++) bits_q.push_back(c[i]);
      while (bits_q.size() >= 8) begin
         for (int i = 0; i < 8; i++) b[i] = bits_q.pop_front();
         push_exp(b);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      bits_q.delete();
      exp_idx = 0;
      got_bytes = 0;
      got_last = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_valid = 1'b0;
      i_data = '0;
      clear_model();
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic send(input logic [23:0] c, input bit use_model);
      int t = 0;
      while (!i_ready && t < 2000) begin
         step();
         t++;
      end
      if (t >= 2000) begin
         errors++;
         $display("FAIL send_timeout i_ready stuck at 0, required 1");
      end
      i_valid = 1'b1;
      i_data = c;
      if (use_model) model_coef(c);
      step();
      i_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         step();
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d bytes outstanding expected 0", name, exp_q.size());
      end
      step();
      step();
   endtask

   initial begin
      vecs[0] = '{'{24'h3FF, 24'h000, 24'h155, 24'h2AA}, '{8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA}, 1'b0};
      vecs[1] = '{'{24'h000400, 24'h001, 24'h002, 24'h003}, '{8'h00, 8'h04, 8'h20, 8'hC0, 8'h00}, 1'b1};
      vecs[2] = '{'{24'h3FF, 24'h3FF, 24'h3FF, 24'h3FF}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b1};
      vecs[3] = '{'{24'h001, 24'h200, 24'h0FF, 24'h100}, '{8'h01, 8'h00, 8'hF8, 8'h0F, 8'h40}, 1'b1};

      // Output monitor: scoreboard pop on each transfer, stability check on stalls.
      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               stall_prev = 1'b0;
            end else begin
               if (stall_prev) begin
                  checks++;
                  if (!o_valid || {o_last, o_data} !== stall_val) begin
                     errors++;
                     $display("FAIL stall_hold got v=%0b last/data=%h expected v=1 last/data=%h",
                              o_valid, {o_last, o_data}, stall_val);
                  end
               end
               if (o_valid && o_ready) begin
                  got_bytes++;
                  if (o_last) got_last++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_byte got last/data=%h expected none", {o_last, o_data});
                  end else begin
                     mon_e = exp_q.pop_front();
                     if ({o_last, o_data} !== mon_e) begin
                        errors++;
                        $display("FAIL byte got last/data=%h expected %h", {o_last, o_data}, mon_e);
                     end
                  end
               end
               stall_prev = o_valid && !o_ready;
               stall_val = {o_last, o_data};
            end
         end
      join_none

      // Reset state
      #2;
      check("rst_i_ready", i_ready, 1);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      check("rst_o_last", o_last, 0);
      check("rst_o_busy", o_busy, 0);
      check("rst_ovf", o_err_ovf, 0);
      check("rst_range", o_err_range, 0);
      do_reset();

      // Table vectors; range flag is sticky across vectors
      for (int v = 0; v < 4; v++) begin
         for (int j = 0; j < 5; j++) push_exp(vecs[v].exp_b[j]);
         for (int j = 0; j < 4; j++) send(vecs[v].coef[j], 1'b0);
         drain("vec");
         check("vec_range", o_err_range, vecs[v].exp_rng);
         check("vec_busy", o_busy, 0);
      end
      check("vec_ovf", o_err_ovf, 0);

      // Full polynomial, o_ready held high
      do_reset();
      for (int i = 0; i < NC; i++) send(24'((i * 37) & 'h3FF), 1'b1);
      drain("poly");
      check("poly_bytes", got_bytes, NB);
      check("poly_last", got_last, 1);
      check("poly_busy", o_busy, 0);

      // Same polynomial with random backpressure and a 50-cycle stall
      do_reset();
      tog_stop = 1'b0;
      fork
         begin
            int n = 0;
            while (!tog_stop) begin
               o_ready = (n >= 100 && n < 150) ? 1'b0 : 1'($urandom_range(0, 1));
               step();
               n++;
            end
         end
      join_none
      for (int i = 0; i < NC; i++) send(24'((i * 37) & 'h3FF), 1'b1);
      tog_stop = 1'b1;
      step();
      step();
      o_ready = 1'b1;
      drain("bp");
      check("bp_bytes", got_bytes, NB);
      check("bp_last", got_last, 1);

      // Overflow: o_ready low, i_valid held high for DEPTH+3 cycles.
      // The FIFO fills plus two coeffs already moved into the accumulator, so DEPTH+2 are taken.
      do_reset();
      o_ready = 1'b0;
      for (int k = 0; k < DEPTH + 3; k++) begin
         i_valid = 1'b1;
         i_data = 24'((k * 5 + 1) & 'h3FF);
         check("ovf_i_ready", i_ready, (k < DEPTH + 2) ? 1 : 0);
         if (k < DEPTH + 2) model_coef(i_data);
         step();
      end
      i_valid = 1'b0;
      check("ovf_flag", o_err_ovf, 1);
      check("ovf_full", i_ready, 0);
      o_ready = 1'b1;
      drain("ovf");
      check("ovf_bytes", got_bytes, ((DEPTH + 2) * 10) / 8);
      check("ovf_busy_partial", o_busy, 1);
      check("ovf_sticky", o_err_ovf, 1);

      // Out-of-range coefficient packs as zero
      do_reset();
      check("range_clear", o_err_range, 0);
      send(24'h000400, 1'b1);
      send(24'h3FF, 1'b1);
      send(24'h3FF, 1'b1);
      send(24'h3FF, 1'b1);
      drain("range");
      check("range_set", o_err_range, 1);
      repeat (10) step();
      check("range_sticky", o_err_range, 1);
      check("range_no_ovf", o_err_ovf, 0);

      // Reset mid-polynomial, then a fresh polynomial
      do_reset();
      for (int i = 0; i < 100; i++) send(24'((i * 37) & 'h3FF) | ((i == 0) ? 24'h001000 : 24'h0), 1'b1);
      check("mid_range", o_err_range, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_i_ready", i_ready, 1);
      check("mid_rst_o_valid", o_valid, 0);
      check("mid_rst_o_data", o_data, 0);
      check("mid_rst_o_last", o_last, 0);
      check("mid_rst_o_busy", o_busy, 0);
      check("mid_rst_range", o_err_range, 0);
      clear_model();
      step();
      rst = 1'b0;
      step();
      for (int i = 0; i < NC; i++) send(24'((i * 37) & 'h3FF), 1'b1);
      drain("post_rst");
      check("post_rst_bytes", got_bytes, NB);
      check("post_rst_last", got_last, 1);
      check("post_rst_busy", o_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
